sync_fifo_flags: RTL
====================

Name: sync_fifo_flags

Overview:
- Single-clock FIFO. Parametrised successor to the dual-clock FIFO.
- Used where producer and consumer share one clock, so no pointer synchronisers are needed.
- Adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.

Parameters:
- DATA_LEN, 8, data word width in bits.
- ADDR_LEN, 5, address width; DEPTH = 2^ADDR_LEN entries.
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through.
- AFULL_THR, 2^ADDR_LEN-2, almost_full asserts when count >= AFULL_THR.
- AEMPTY_THR, 2, almost_empty asserts when count <= AEMPTY_THR.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_LEN  write word.
- rd_en  in  1  read (pop) request.
- clr_err  in  1  clears overflow/underflow.
- rd_data  out  DATA_LEN  read word.
- rd_valid  out  1  rd_data holds a valid word.
- wr_full  out  1  count == DEPTH.
- rd_empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_THR.
- almost_empty  out  1  count <= AEMPTY_THR.
- count  out  ADDR_LEN+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (async assert, any cycle including mid-transfer):
  - Pointers and count go to 0.
  - rd_empty=1, almost_empty=1, wr_full=0, almost_full=0.
  - rd_data=0, rd_valid=0, overflow=0, underflow=0.
  - Memory contents are not reset; stale data is never exposed.
- Pointers: binary, ADDR_LEN+1 bits. Low ADDR_LEN bits address memory. Pointers wrap naturally at 2^(ADDR_LEN+1).
- Acceptance rules:
  - Write accepted iff wr_en && !wr_full.
  - Read accepted iff rd_en && !rd_empty.
  - Acceptance is evaluated on the registered flags at the clock edge.
- count update:
  - +1 on write only, -1 on read only, unchanged on both or neither.
  - Simultaneous read and write while full: read accepted, write rejected, overflow set, count = DEPTH-1.
  - Simultaneous read and write while empty: write accepted, read rejected, underflow set, count = 1.
  - No write-to-read bypass.
- Flags (wr_full, rd_empty, almost_full, almost_empty) are registered. Each is computed from the next-count value, so it always agrees with count in the same cycle.
- Standard mode (FWFT=0):
  - Accepted read at edge N: rd_data updates at edge N+1; rd_valid=1 for that one cycle.
  - rd_data holds its value otherwise; rd_valid is 0 otherwise.
  - Read latency is 1 cycle.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_addr], a combinational read of the head entry.
  - rd_valid = !rd_empty.
  - A word written into an empty FIFO at edge N appears with rd_valid=1 after edge N (same cycle rd_empty drops).
  - An accepted rd_en pops; the next word is shown after the edge.
- Error flags:
  - overflow sets on wr_en && wr_full; underflow sets on rd_en && rd_empty.
  - Both stay set until clr_err.
  - If set and clear occur in the same cycle, set wins.
- Threshold constraints: 0 < AFULL_THR <= DEPTH and 0 <= AEMPTY_THR < DEPTH. Out-of-range values are an elaboration error (generate-time check).

Test Plan:
- Reset then 32 writes (0x00..0x1F), ADDR_LEN=5, FWFT=0:
  - almost_full rises at count=30; wr_full=1 at count=32.
  - 33rd write leaves count=32 and sets overflow=1.
- Drain 32 reads:
  - rd_data = 0x00..0x1F in order, each one cycle after its rd_en, with rd_valid pulses.
  - almost_empty at count<=2; rd_empty at 0.
  - Extra read sets underflow; clr_err clears both flags.
- Full FIFO, wr_en=rd_en=1 for one cycle:
  - count 32 -> 31, overflow=1, head word popped.
  - Same on empty FIFO: count 0 -> 1, underflow=1.
- Wrap-around:
  - Stream 100 words with continuous overlapped read/write at depth 16.
  - All words are received in order; count never exceeds 16.
- FWFT=1:
  - Write 0xA5 into empty FIFO: next cycle rd_valid=1 and rd_data=0xA5 without rd_en.
  - rd_en pops it; rd_empty=1.
- Reset mid-operation with count=10:
  - Assert rst between edges: outputs go to reset values immediately, without waiting for a clock edge.
  - After release, the first written word is the first read back.

Source files
------------

// File: rtl/sync_fifo_flags_if.sv
// sync_fifo_flags_if: write/read/status bundle for the single-clock flagged FIFO
//   master: drives wr_en, wr_data, rd_en, clr_err; observes all status/read outputs
//   slave : the FIFO side, mirror of master
interface sync_fifo_flags_if #(
    parameter int DATA_LEN = 8,
    parameter int ADDR_LEN = 5
);
    logic                wr_en;
    logic [DATA_LEN-1:0] wr_data;
    logic                rd_en;
    logic                clr_err;
    logic [DATA_LEN-1:0] rd_data;
    logic                rd_valid;
    logic                wr_full;
    logic                rd_empty;
    logic                almost_full;
    logic                almost_empty;
    logic [ADDR_LEN:0]   count;
    logic                overflow;
    logic                underflow;

    modport master (
        output wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, wr_full, rd_empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, wr_full, rd_empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, almost flags, sticky errors, optional FWFT
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : sync_fifo_flags_if.slave (wr_en/wr_data/rd_en/clr_err in; rd_data/rd_valid,
//         wr_full/rd_empty, almost_full/almost_empty, count, overflow/underflow out)
module sync_fifo_flags #(
    parameter int DATA_LEN   = 8,
    parameter int ADDR_LEN   = 5,
    parameter bit FWFT       = 1'b0,
    parameter int AFULL_THR  = 2**ADDR_LEN - 2,
    parameter int AEMPTY_THR = 2
) (
    input logic              clk,
    input logic              rst,
    sync_fifo_flags_if.slave bus
);
    localparam int DEPTH = 2**ADDR_LEN;
    localparam logic [ADDR_LEN:0] ONE = (ADDR_LEN+1)'(1);
    localparam logic [ADDR_LEN:0] AF  = (ADDR_LEN+1)'(AFULL_THR);
    localparam logic [ADDR_LEN:0] AE  = (ADDR_LEN+1)'(AEMPTY_THR);

    generate
        if (AFULL_THR <= 0 || AFULL_THR > DEPTH) begin : g_bad_afull
            $error("sync_fifo_flags: AFULL_THR must satisfy 0 < AFULL_THR <= DEPTH");
        end
        if (AEMPTY_THR < 0 || AEMPTY_THR >= DEPTH) begin : g_bad_aempty
            $error("sync_fifo_flags: AEMPTY_THR must satisfy 0 <= AEMPTY_THR < DEPTH");
        end
    endgenerate

    logic [DATA_LEN-1:0] mem [DEPTH];
    logic [ADDR_LEN:0]   wr_ptr, rd_ptr, cnt, cnt_nxt;
    logic                full, empty, afull, aempty, ovf, udf;
    logic                wr_ok, rd_ok;
    logic [ADDR_LEN-1:0] waddr, raddr;

    // acceptance uses the registered flags, so full-and-read still rejects the write
    assign wr_ok   = bus.wr_en && !full;
    assign rd_ok   = bus.rd_en && !empty;
    assign waddr   = wr_ptr[ADDR_LEN-1:0];
    assign raddr   = rd_ptr[ADDR_LEN-1:0];
    assign cnt_nxt = cnt + (wr_ok ? ONE : '0) - (rd_ok ? ONE : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            afull  <= 1'b0;
            aempty <= 1'b1;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + ONE;
            if (rd_ok) rd_ptr <= rd_ptr + ONE;
            cnt    <= cnt_nxt;
            // flags follow the next count so they line up with count every cycle
            full   <= cnt_nxt[ADDR_LEN];
            empty  <= cnt_nxt == '0;
            afull  <= cnt_nxt >= AF;
            aempty <= cnt_nxt <= AE;
            // set has priority over clear
            ovf    <= (bus.wr_en && full) || (ovf && !bus.clr_err);
            udf    <= (bus.rd_en && empty) || (udf && !bus.clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[waddr] <= bus.wr_data;
    end

    generate
        if (FWFT) begin : g_fwft
            // head entry is shown combinationally; masked while empty so stale data never leaks
            assign bus.rd_data  = empty ? '0 : mem[raddr];
            assign bus.rd_valid = !empty;
        end else begin : g_std
            logic [DATA_LEN-1:0] rd_q;
            logic                rd_v;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_q <= '0;
                    rd_v <= 1'b0;
                end else begin
                    rd_v <= rd_ok;
                    if (rd_ok) rd_q <= mem[raddr];
                end
            end
            assign bus.rd_data  = rd_q;
            assign bus.rd_valid = rd_v;
        end
    endgenerate

    assign bus.count        = cnt;
    assign bus.wr_full      = full;
    assign bus.rd_empty     = empty;
    assign bus.almost_full  = afull;
    assign bus.almost_empty = aempty;
    assign bus.overflow     = ovf;
    assign bus.underflow    = udf;
endmodule
